// File: rtl/mem_bus_pkg.sv
// Shared state encoding and default widths for the memory-bus initiator.
package mem_bus_pkg;

   localparam int DATA_WIDTH_DEF    = 32;
   localparam int ADDRESS_WIDTH_DEF = 8;
   localparam int LEN_WIDTH_DEF     = 4;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WR_FETCH = 3'd1,
      WR_BEAT  = 3'd2,
      RD_REQ   = 3'd3,
      RD_DATA  = 3'd4,
      TURN     = 3'd5
   } state_e;

endpackage

// File: rtl/mem_bus_master.sv
// Burst initiator for the single-port memory bus: reads return beat 0 two edges after accept, then 1 beat/cycle.
// Writes stream at 1 beat/cycle while wr_valid holds; read data has no backpressure; bus pins come only from registers.
module mem_bus_master
   import mem_bus_pkg::*;
#(
   parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
   parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
   parameter int LEN_WIDTH     = LEN_WIDTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic                     cmd_write,
   input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
   input  logic [LEN_WIDTH-1:0]     cmd_len,
   input  logic                     wr_valid,
   input  logic [DATA_WIDTH-1:0]    wr_data,
   output logic                     wr_ready,
   output logic                     rd_valid,
   output logic [DATA_WIDTH-1:0]    rd_data,
   output logic                     done,
   output logic                     busy,
   output logic                     mem_sel,
   output logic                     mem_w_en,
   output logic [ADDRESS_WIDTH-1:0] mem_address_bus,
   inout  wire  [DATA_WIDTH-1:0]    mem_data_bus
);

   state_e                    state_q, state_d;
   logic [ADDRESS_WIDTH-1:0]  addr_q, addr_d;
   logic [LEN_WIDTH-1:0]      rem_q, rem_d;
   logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0]     rd_data_q, rd_data_d;
   logic                      rd_valid_q, rd_valid_d;
   logic                      done_q, done_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         rem_q      <= '0;
         wdata_q    <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         rem_q      <= rem_d;
         wdata_q    <= wdata_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      rem_d      = rem_q;
      wdata_d    = wdata_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      done_d     = 1'b0;
      cmd_ready  = 1'b0;
      wr_ready   = 1'b0;

      case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               addr_d  = cmd_addr;
               rem_d   = cmd_len;
               state_d = cmd_write ? WR_FETCH : RD_REQ;
            end
         end

         WR_FETCH: begin
            wr_ready = 1'b1;
            if (wr_valid) begin
               wdata_d = wr_data;
               state_d = WR_BEAT;
            end
         end

         WR_BEAT: begin
            // Accepting the next beat here keeps the bus writing every cycle.
            wr_ready = (rem_q != '0);
            if (rem_q == '0) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               addr_d = addr_q + 1'b1;
               rem_d  = rem_q - 1'b1;
               if (wr_valid) begin
                  wdata_d = wr_data;
               end else begin
                  state_d = WR_FETCH;
               end
            end
         end

         RD_REQ: begin
            state_d = RD_DATA;
            if (rem_q != '0) begin
               addr_d = addr_q + 1'b1;
            end
         end

         RD_DATA: begin
            // Bus holds the word addressed last cycle; address already points one beat ahead.
            rd_valid_d = 1'b1;
            rd_data_d  = mem_data_bus;
            if (rem_q == '0) begin
               done_d  = 1'b1;
               state_d = TURN;
            end else begin
               rem_d = rem_q - 1'b1;
               if (rem_q != LEN_WIDTH'(1)) begin
                  addr_d = addr_q + 1'b1;
               end
            end
         end

         TURN: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy            = (state_q != IDLE);
   assign mem_sel         = (state_q == WR_BEAT) || (state_q == RD_REQ) || (state_q == RD_DATA);
   assign mem_w_en        = (state_q == WR_BEAT);
   assign mem_address_bus = addr_q;
   assign rd_valid        = rd_valid_q;
   assign rd_data         = rd_data_q;
   assign done            = done_q;

   // Only drive while writing; the memory owns the bus during reads.
   assign mem_data_bus = (state_q == WR_BEAT) ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench for mem_bus_master with a behavioural memory responder and a cycle-level scoreboard.
module tb_mem_bus_master;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_write = 1'b0;
   logic [7:0]  cmd_addr = '0;
   logic [3:0]  cmd_len = '0;
   logic        wr_valid = 1'b0;
   logic [31:0] wr_data = '0;
   logic        wr_ready;
   logic        rd_valid;
   logic [31:0] rd_data;
   logic        done;
   logic        busy;
   logic        mem_sel;
   logic        mem_w_en;
   logic [7:0]  mem_address_bus;
   wire  [31:0] mem_data_bus;

   always #5 clk = ~clk;

   mem_bus_master #(.DATA_WIDTH(32), .ADDRESS_WIDTH(8), .LEN_WIDTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
      .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .busy(busy),
      .mem_sel(mem_sel), .mem_w_en(mem_w_en),
      .mem_address_bus(mem_address_bus), .mem_data_bus(mem_data_bus)
   );

   function automatic logic [31:0] pat(input int a);
      return 32'hA500_0000 | 32'(a);
   endfunction

   // Memory responder: writes land on the edge ending a write cycle; reads register then drive.
   logic [31:0] mem [256];
   logic [31:0] mem_rd_q = '0;
   logic        mem_drv_q = 1'b0;
   logic        mem_init_q = 1'b0;
   int          wr_cnt = 0;

   always @(posedge clk) begin
      if (!mem_init_q) begin
         for (int i = 0; i < 256; i++) mem[i] <= pat(i);
         mem_init_q <= 1'b1;
      end else if (mem_sel && mem_w_en) begin
         mem[mem_address_bus] <= mem_data_bus;
         wr_cnt <= wr_cnt + 1;
      end
      if (mem_sel && !mem_w_en) mem_rd_q <= mem[mem_address_bus];
      mem_drv_q <= mem_sel && !mem_w_en;
   end

   assign mem_data_bus = (mem_drv_q && mem_sel && !mem_w_en) ? mem_rd_q : 32'hzzzz_zzzz;

   int n_chk = 0;
   int n_pass = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, got, exp);
   endtask

   // Scoreboard: every accepted command/beat schedules the cycles at which its effects must appear.
   typedef struct {
      int          cyc;
      logic [7:0]  a;
      logic [31:0] d;
   } ev_t;

   ev_t         wq[$];
   ev_t         rq[$];
   int          dq[$];
   bit          sel_map[int];
   logic [31:0] ref_mem [256];
   int          cyc = 0;
   int          idle_from = 0;
   bit          wr_act = 1'b0;
   logic [7:0]  wbase = '0;
   int          wlen = 0;
   int          widx = 0;
   logic [7:0]  ma;
   bit          exp_cmd_rdy, exp_wr_rdy, want;

   initial begin
      for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            wq.delete(); rq.delete(); dq.delete(); sel_map.delete();
            idle_from = 0;
            wr_act = 1'b0;
         end else begin
            exp_cmd_rdy = (cyc >= idle_from);
            exp_wr_rdy  = wr_act;
            check("cmd_ready", 64'(cmd_ready), 64'(exp_cmd_rdy));
            check("busy", 64'(busy), 64'(!exp_cmd_rdy));
            check("wr_ready", 64'(wr_ready), 64'(exp_wr_rdy));
            check("mem_sel", 64'(mem_sel), 64'(sel_map.exists(cyc)));

            want = (wq.size() > 0) && (wq[0].cyc == cyc);
            check("wr_beat", 64'(mem_sel && mem_w_en), 64'(want));
            if (want) begin
               check("wr_addr", 64'(mem_address_bus), 64'(wq[0].a));
               check("wr_data", 64'(mem_data_bus), 64'(wq[0].d));
               void'(wq.pop_front());
            end

            want = (rq.size() > 0) && (rq[0].cyc == cyc);
            check("rd_valid", 64'(rd_valid), 64'(want));
            if (want) begin
               check("rd_data", 64'(rd_data), 64'(rq[0].d));
               void'(rq.pop_front());
            end

            want = (dq.size() > 0) && (dq[0] == cyc);
            check("done", 64'(done), 64'(want));
            if (want) void'(dq.pop_front());

            if (cmd_valid && exp_cmd_rdy) begin
               if (cmd_write) begin
                  wr_act = 1'b1;
                  wbase = cmd_addr;
                  wlen = int'(cmd_len);
                  widx = 0;
                  idle_from = 32'h7fff_ffff;
               end else begin
                  for (int i = 0; i <= int'(cmd_len); i++) begin
                     ma = cmd_addr + 8'(i);
                     rq.push_back('{cyc + 3 + i, ma, ref_mem[ma]});
                  end
                  for (int c = cyc + 1; c <= cyc + 2 + int'(cmd_len); c++) sel_map[c] = 1'b1;
                  dq.push_back(cyc + 3 + int'(cmd_len));
                  idle_from = cyc + 4 + int'(cmd_len);
               end
            end

            if (wr_valid && exp_wr_rdy) begin
               ma = wbase + 8'(widx);
               ref_mem[ma] = wr_data;
               wq.push_back('{cyc + 1, ma, wr_data});
               sel_map[cyc + 1] = 1'b1;
               if (widx == wlen) begin
                  dq.push_back(cyc + 2);
                  idle_from = cyc + 2;
                  wr_act = 1'b0;
               end
               widx++;
            end
         end
      end
   end

   // Stimulus helpers: inputs change just after the rising edge.
   task automatic send_cmd(input logic w, input logic [7:0] a, input logic [3:0] l);
      int t = 0;
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
      @(negedge clk);
      while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
      check("cmd_handshake", 64'(t < 50), 64'(1));
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic send_beat(input logic [31:0] d);
      int t = 0;
      wr_valid = 1'b1; wr_data = d;
      @(negedge clk);
      while (!wr_ready && t < 50) begin @(negedge clk); t++; end
      check("wr_handshake", 64'(t < 50), 64'(1));
      @(posedge clk); #1;
      wr_valid = 1'b0;
   endtask

   task automatic gap(input int n);
      repeat (n) begin
         @(posedge clk); #2;
         check("gap_sel", 64'(mem_sel), 64'(0));
      end
   endtask

   task automatic wait_idle();
      int t = 0;
      @(negedge clk);
      while (busy && t < 60) begin @(negedge clk); t++; end
      check("idle_reached", 64'(busy), 64'(0));
   endtask

   logic [31:0] got[$];

   task automatic collect(input int n, output int first_it, output int last_it, output int done_it);
      got.delete();
      first_it = -1; last_it = -1; done_it = -1;
      for (int it = 1; it <= 40 && (got.size() < n || done_it < 0); it++) begin
         @(negedge clk);
         if (rd_valid) begin
            if (first_it < 0) first_it = it;
            last_it = it;
            got.push_back(rd_data);
         end
         if (done) done_it = it;
      end
      check("rd_beat_count", 64'(got.size()), 64'(n));
   endtask

   function automatic logic [31:0] got_at(input int i);
      return (got.size() > i) ? got[i] : 32'hXXXX_0BAD;
   endfunction

   logic [31:0] t2_vals [4] = '{32'd1, 32'd2, 32'd3, 32'd4};
   logic [7:0]  t2_addr [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};

   initial begin
      int f, l, d, w0, nd, mism;

      @(posedge clk); #1;
      check("rst_mem_sel", 64'(mem_sel), 64'(0));
      check("rst_mem_w_en", 64'(mem_w_en), 64'(0));
      check("rst_rd_valid", 64'(rd_valid), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_wr_ready", 64'(wr_ready), 64'(0));
      check("rst_addr", 64'(mem_address_bus), 64'(0));
      check("rst_rd_data", 64'(rd_data), 64'(0));
      check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
      @(posedge clk); @(posedge clk); #2;
      rst_n = 1'b1;

      // 1: single write then single read with latency pinned
      send_cmd(1'b1, 8'h10, 4'd0);
      send_beat(32'hDEADBEEF);
      wait_idle();
      check("t1_mem", 64'(mem[8'h10]), 64'(32'hDEADBEEF));
      send_cmd(1'b0, 8'h10, 4'd0);
      collect(1, f, l, d);
      check("t1_latency", 64'(f), 64'(3));
      check("t1_rd_data", 64'(got_at(0)), 64'(32'hDEADBEEF));
      check("t1_done_with_last", 64'(d), 64'(l));
      wait_idle();

      // 2: streamed burst across the address wrap, then read back
      w0 = wr_cnt;
      send_cmd(1'b1, 8'hFE, 4'd3);
      for (int i = 0; i < 4; i++) send_beat(t2_vals[i]);
      wait_idle();
      check("t2_write_count", 64'(wr_cnt - w0), 64'(4));
      for (int i = 0; i < 4; i++) check("t2_mem", 64'(mem[t2_addr[i]]), 64'(t2_vals[i]));
      send_cmd(1'b0, 8'hFE, 4'd3);
      collect(4, f, l, d);
      check("t2_consecutive", 64'(l - f), 64'(3));
      for (int i = 0; i < 4; i++) check("t2_rd_data", 64'(got_at(i)), 64'(t2_vals[i]));
      check("t2_done_with_last", 64'(d), 64'(l));
      wait_idle();

      // 3: write with stalls between beats
      w0 = wr_cnt;
      send_cmd(1'b1, 8'h40, 4'd2);
      send_beat(32'hA1A1_0001);
      gap(2);
      send_beat(32'hA1A1_0002);
      gap(2);
      send_beat(32'hA1A1_0003);
      wait_idle();
      check("t3_write_count", 64'(wr_cnt - w0), 64'(3));
      check("t3_below", 64'(mem[8'h3F]), 64'(pat(8'h3F)));
      check("t3_above", 64'(mem[8'h43]), 64'(pat(8'h43)));
      check("t3_mid", 64'(mem[8'h41]), 64'(32'hA1A1_0002));

      // 4: read immediately followed by a write needs the turnaround cycle
      send_cmd(1'b0, 8'h10, 4'd0);
      @(posedge clk); @(posedge clk); #2;
      check("t4_turn_sel", 64'(mem_sel), 64'(0));
      check("t4_turn_busy", 64'(busy), 64'(1));
      send_cmd(1'b1, 8'h20, 4'd0);
      send_beat(32'h1234_5678);
      wait_idle();
      check("t4_mem", 64'(mem[8'h20]), 64'(32'h1234_5678));
      send_cmd(1'b0, 8'h10, 4'd0);
      collect(1, f, l, d);
      check("t4_rdback", 64'(got_at(0)), 64'(32'hDEADBEEF));
      wait_idle();

      // 5: reset during a long read
      send_cmd(1'b0, 8'h00, 4'd7);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("t5_sel", 64'(mem_sel), 64'(0));
      check("t5_w_en", 64'(mem_w_en), 64'(0));
      check("t5_rd_valid", 64'(rd_valid), 64'(0));
      check("t5_done", 64'(done), 64'(0));
      check("t5_busy", 64'(busy), 64'(0));
      @(posedge clk); @(posedge clk); #2;
      rst_n = 1'b1;
      #1;
      check("t5_cmd_ready", 64'(cmd_ready), 64'(1));
      nd = 0;
      repeat (12) begin @(negedge clk); if (done || rd_valid) nd++; end
      check("t5_no_done", 64'(nd), 64'(0));
      check("t5_mem_kept", 64'(mem[8'h00]), 64'(32'd3));

      // 6: command and write data presented while a read is in flight
      w0 = wr_cnt;
      send_cmd(1'b0, 8'hFE, 4'd3);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h10; cmd_len = 4'd0;
      wr_valid = 1'b1; wr_data = 32'hFFFF_FFFF;
      #1;
      check("t6_cmd_ready", 64'(cmd_ready), 64'(0));
      check("t6_wr_ready", 64'(wr_ready), 64'(0));
      @(posedge clk); #1;
      cmd_valid = 1'b0; wr_valid = 1'b0;
      collect(4, f, l, d);
      check("t6_consecutive", 64'(l - f), 64'(3));
      for (int i = 0; i < 4; i++) check("t6_rd_data", 64'(got_at(i)), 64'(t2_vals[i]));
      check("t6_done_with_last", 64'(d), 64'(l));
      wait_idle();
      check("t6_no_write", 64'(wr_cnt - w0), 64'(0));
      check("t6_mem_kept", 64'(mem[8'h10]), 64'(32'hDEADBEEF));

      mism = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) mism++;
      check("mem_image", 64'(mism), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", n_pass, n_chk);
      $fatal(1);
   end

endmodule
